// File: rtl/fetch_pkg.sv
// Shared types and sizes for the instruction fetch sequencer.
//   fetch_state_e : fetch FSM states
//   FETCH_ADDR_W  : PC / instruction-memory address width
//   FETCH_INSTR_W : instruction width
//   FETCH_PERF_W  : width of the optional performance counters
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 10;
  localparam int unsigned FETCH_INSTR_W = 16;
  localparam int unsigned FETCH_PERF_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter for fetch performance monitoring.
//   clk, reset : clock and asynchronous active-high reset
//   clr_i      : synchronous clear, wins over inc_i
//   inc_i      : count one event this cycle
//   cnt_o      : current count, sticks at all-ones
module fetch_perf_counter
  import fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [FETCH_PERF_W-1:0] cnt_o
);

  logic [FETCH_PERF_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues req/ack reads to instruction memory and
// hands one fetched instruction at a time to decode over valid/ready. Branch redirects may
// arrive in any state, including while a read is in flight (the read is then drained).
//   clk, reset        : clock and asynchronous active-high reset
//   run_i             : fetch enable, stops at the next fetch boundary when low
//   imem_req_o/addr_o : memory read request, held with stable address until imem_ack_i
//   imem_ack_i/rdata_i: read completion and data
//   if_valid_o/instr_o/pc_o, id_ready_i : decode handshake
//   redirect_valid_i/addr_i : one-cycle branch/jump target
// Optional build macro FETCH_PERF_EN adds perf_clr_i, perf_fetch_cnt_o, perf_stall_cnt_o.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [ADDR_W-1:0]  if_pc_o,
  input  logic               id_ready_i,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_addr_i
`ifdef FETCH_PERF_EN
  ,
  input  logic                    perf_clr_i,
  output logic [FETCH_PERF_W-1:0] perf_fetch_cnt_o,
  output logic [FETCH_PERF_W-1:0] perf_stall_cnt_o
`endif
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;

  logic              accept;
  logic [ADDR_W-1:0] target;

  assign accept = if_valid_q & id_ready_i;
  // Address of the next read to issue: a redirect this cycle overrides the sequential PC.
  assign target = redirect_valid_i ? redirect_addr_i : pc_q;

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      imem_addr_q <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_addr_q <= imem_addr_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // A redirect in IDLE only retargets the PC.
        if (!redirect_valid_i && run_i) state_d = StFetch;
      end
      StFetch: begin
        if (redirect_valid_i) begin
          // Unfinished read must be drained; a finished one is simply dropped.
          state_d = imem_ack_i ? StFetch : StDrain;
        end else if (imem_ack_i) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (redirect_valid_i || accept) state_d = run_i ? StFetch : StIdle;
      end
      StDrain: begin
        if (imem_ack_i) state_d = run_i ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values.
  always_comb begin
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    if (redirect_valid_i) begin
      pc_d = redirect_addr_i;
    end else if ((state_q == StFetch) && imem_ack_i) begin
      pc_d = pc_q + 1'b1;
    end

    if (redirect_valid_i) begin
      if_valid_d = 1'b0;
    end else if ((state_q == StFetch) && imem_ack_i) begin
      if_valid_d = 1'b1;
      if_instr_d = imem_rdata_i;
      if_pc_d    = imem_addr_q;
    end else if (accept) begin
      if_valid_d = 1'b0;
    end

    // Address only moves when a new read starts; it stays put through FETCH and DRAIN waits.
    if ((state_d == StFetch) && ((state_q != StFetch) || imem_ack_i)) begin
      imem_addr_d = target;
    end else begin
      imem_addr_d = imem_addr_q;
    end
  end

  // Outputs, all taken straight from registers.
  always_comb begin
    imem_req_o  = (state_q == StFetch) || (state_q == StDrain);
    imem_addr_o = imem_addr_q;
    if_valid_o  = if_valid_q;
    if_instr_o  = if_instr_q;
    if_pc_o     = if_pc_q;
  end

`ifdef FETCH_PERF_EN
  fetch_perf_counter u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (perf_clr_i),
    .inc_i (accept),
    .cnt_o (perf_fetch_cnt_o)
  );

  fetch_perf_counter u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (perf_clr_i),
    .inc_i (imem_req_o & ~imem_ack_i),
    .cnt_o (perf_stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small wait-state memory model
// (rdata = addr ^ 0xA5A5, ack after mem_wait stall cycles).
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [9:0]  if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [9:0]  redirect_addr;
`ifdef FETCH_PERF_EN
  logic        perf_clr;
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned mem_wait;
  int unsigned wait_cnt;

  fetch_sequencer u_dut (
    .clk              (clk),
    .reset            (reset),
    .run_i            (run),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_ack_i       (imem_ack),
    .imem_rdata_i     (imem_rdata),
    .if_valid_o       (if_valid),
    .if_instr_o       (if_instr),
    .if_pc_o          (if_pc),
    .id_ready_i       (id_ready),
    .redirect_valid_i (redirect_valid),
    .redirect_addr_i  (redirect_addr)
`ifdef FETCH_PERF_EN
    ,
    .perf_clr_i       (perf_clr),
    .perf_fetch_cnt_o (perf_fetch_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack once the request has waited mem_wait cycles.
  assign imem_ack   = imem_req && (wait_cnt >= mem_wait);
  assign imem_rdata = {6'b0, imem_addr} ^ 16'hA5A5;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 0;
    end else if (imem_req && !imem_ack) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    mem_wait       = 0;
    reset          = 1'b1;
    run            = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
`ifdef FETCH_PERF_EN
    perf_clr       = 1'b0;
`endif
    tick();
    tick();
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_addr", imem_addr, 0);
    check_eq("rst_valid", if_valid, 0);
    check_eq("rst_instr", if_instr, 0);
    check_eq("rst_pc", if_pc, 0);
    reset = 1'b0;

    // 1: zero-wait streaming, one instruction every two cycles.
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t1_req", imem_req, 1);
      check_eq("t1_addr", imem_addr, i);
      tick();
      check_eq("t1_valid", if_valid, 1);
      check_eq("t1_pc", if_pc, i);
      check_eq("t1_instr", if_instr, i ^ 16'hA5A5);
    end
    tick();  // FETCH 4
    tick();  // HOLD 4

    // 2: three wait states at pc 5.
    mem_wait = 3;
    tick();
    for (int k = 0; k < 4; k++) begin
      check_eq("t2_req", imem_req, 1);
      check_eq("t2_addr", imem_addr, 5);
      check_eq("t2_valid", if_valid, 0);
      tick();
    end
    check_eq("t2_valid_late", if_valid, 1);
    check_eq("t2_pc", if_pc, 5);
    check_eq("t2_req_low", imem_req, 0);

    // 3: redirect during an in-flight read drains it.
    mem_wait = 2;
    tick();
    check_eq("t3_addr6", imem_addr, 6);
    redirect_valid = 1'b1;
    redirect_addr  = 10'h040;
    tick();
    redirect_valid = 1'b0;
    check_eq("t3_drain_req", imem_req, 1);
    check_eq("t3_drain_addr", imem_addr, 6);
    check_eq("t3_drain_valid", if_valid, 0);
    tick();
    check_eq("t3_drain_addr2", imem_addr, 6);
    tick();
    check_eq("t3_new_addr", imem_addr, 10'h040);
    check_eq("t3_dropped", if_valid, 0);
    mem_wait = 0;
    tick();
    check_eq("t3_pc", if_pc, 10'h040);
    check_eq("t3_instr", if_instr, 16'hA5E5);

    // 4: redirect drops an instruction held by a stalled decode.
    redirect_valid = 1'b1;
    redirect_addr  = 10'h010;
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    check_eq("t4_addr10", imem_addr, 10'h010);
    tick();
    check_eq("t4_held_pc", if_pc, 10'h010);
    check_eq("t4_held_instr", if_instr, 16'hA5B5);
    tick();
    check_eq("t4_still_valid", if_valid, 1);
    check_eq("t4_hold_req", imem_req, 0);
    redirect_valid = 1'b1;
    redirect_addr  = 10'h200;
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    check_eq("t4_dropped", if_valid, 0);
    check_eq("t4_addr200", imem_addr, 10'h200);
    tick();
    check_eq("t4_pc", if_pc, 10'h200);
    check_eq("t4_instr", if_instr, 16'hA7A5);

    // 5: PC wraps from 0x3FF to 0x000.
    redirect_valid = 1'b1;
    redirect_addr  = 10'h3FF;
    tick();
    redirect_valid = 1'b0;
    tick();
    check_eq("t5_pc3ff", if_pc, 10'h3FF);
    check_eq("t5_instr3ff", if_instr, 16'hA65A);
    tick();
    check_eq("t5_wrap_addr", imem_addr, 0);
    tick();
    check_eq("t5_pc0", if_pc, 0);
    check_eq("t5_instr0", if_instr, 16'hA5A5);

    // 6: run=0 mid-read completes, holds until consumed, then idles.
    mem_wait = 1;
    tick();
    check_eq("t6_req", imem_req, 1);
    run      = 1'b0;
    id_ready = 1'b0;
    tick();
    check_eq("t6_req_kept", imem_req, 1);
    check_eq("t6_addr", imem_addr, 1);
    tick();
    check_eq("t6_valid", if_valid, 1);
    check_eq("t6_pc", if_pc, 1);
    check_eq("t6_req_off", imem_req, 0);
    tick();
    check_eq("t6_hold", if_valid, 1);
    id_ready = 1'b1;
    tick();
    check_eq("t6_idle_valid", if_valid, 0);
    check_eq("t6_idle_req", imem_req, 0);
    tick();
    check_eq("t6_idle_req2", imem_req, 0);

    // Async reset while draining.
    run      = 1'b1;
    mem_wait = 5;
    tick();
    check_eq("t6_fetch_addr", imem_addr, 2);
    redirect_valid = 1'b1;
    redirect_addr  = 10'h123;
    tick();
    redirect_valid = 1'b0;
    check_eq("t6_drain_req", imem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_arst_req", imem_req, 0);
    check_eq("t6_arst_addr", imem_addr, 0);
    check_eq("t6_arst_valid", if_valid, 0);
    check_eq("t6_arst_instr", if_instr, 0);
    check_eq("t6_arst_pc", if_pc, 0);
    tick();
    reset    = 1'b0;
    mem_wait = 4;

    // Restart from RESET_PC; first read stalls four cycles, then three accepts.
    tick();
    check_eq("t7_addr0", imem_addr, 0);
    for (int k = 0; k < 4; k++) tick();
    mem_wait = 0;
    tick();
    check_eq("t7_valid", if_valid, 1);
    check_eq("t7_pc", if_pc, 0);
    tick();
    tick();
    tick();
    tick();
    run = 1'b0;
    tick();
    check_eq("t7_idle", imem_req, 0);
`ifdef FETCH_PERF_EN
    check_eq("perf_fetch", perf_fetch_cnt, 3);
    check_eq("perf_stall", perf_stall_cnt, 4);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check_eq("perf_fetch_clr", perf_fetch_cnt, 0);
    check_eq("perf_stall_clr", perf_stall_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
